// File: rtl/matmul_fsmd_param.sv
`default_nettype none
// ============================================================================
// Module   : matmul_fsmd_param
// Brief    : NxN unsigned matrix multiply FSMD. Reads A/B from synchronous
//            RAMs and streams C row-major over valid/ready, then pulses DONE.
// Revision : 1.0 - initial parameterised release
// ============================================================================
module matmul_fsmd_param #(
    parameter  int N     = 3,
    parameter  int DW    = 8,
    parameter  int OW    = 8,
    parameter  int SAT   = 1,
    localparam int AW    = (N * N > 1) ? $clog2(N * N) : 1,
    localparam int IW    = (N > 1) ? $clog2(N) : 1,
    localparam int ACC_W = 2 * DW + IW
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          go_i,
    output logic          READ_EN_A,
    output logic [AW-1:0] ADDR_A,
    input  logic [DW-1:0] DATA_A,
    output logic          READ_EN_B,
    output logic [AW-1:0] ADDR_B,
    input  logic [DW-1:0] DATA_B,
    output logic          OUT_VALID,
    input  logic          OUT_READY,
    output logic [OW-1:0] OUT,
    output logic [IW-1:0] OUT_ROW,
    output logic [IW-1:0] OUT_COL,
    output logic          BUSY,
    output logic          DONE
);

    localparam logic [2:0] c_IDLE = 3'd0;
    localparam logic [2:0] c_RD   = 3'd1;
    localparam logic [2:0] c_MAC  = 3'd2;
    localparam logic [2:0] c_EMIT = 3'd3;
    localparam logic [2:0] c_FIN  = 3'd4;

    localparam logic [IW-1:0] c_LAST = IW'(N - 1);

    logic [2:0]       r_state;
    logic [IW-1:0]    r_i;
    logic [IW-1:0]    r_j;
    logic [IW-1:0]    r_k;
    logic [ACC_W-1:0] r_sum;
    logic [OW-1:0]    r_out;

    logic [2*DW-1:0]  w_prod;
    logic [ACC_W-1:0] w_sum_next;
    logic [OW-1:0]    w_out_map;
    logic             w_rd;
    logic             w_emit;

    assign w_prod     = {{DW{1'b0}}, DATA_A} * {{DW{1'b0}}, DATA_B};
    assign w_sum_next = r_sum + {{(ACC_W - 2*DW){1'b0}}, w_prod};

    // Output mapping is chosen at elaboration; a wide enough output never clips.
    generate
        if (OW >= ACC_W) begin : g_wide
            assign w_out_map = OW'(w_sum_next);
        end else if (SAT != 0) begin : g_sat
            assign w_out_map = (|w_sum_next[ACC_W-1:OW]) ? {OW{1'b1}}
                                                         : w_sum_next[OW-1:0];
        end else begin : g_trunc
            assign w_out_map = w_sum_next[OW-1:0];
        end
    endgenerate

    always_ff @(posedge CLK) begin
        if (!RST) begin
            r_state <= c_IDLE;
            r_i     <= '0;
            r_j     <= '0;
            r_k     <= '0;
            r_sum   <= '0;
            r_out   <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (go_i) begin
                        r_i     <= '0;
                        r_j     <= '0;
                        r_k     <= '0;
                        r_sum   <= '0;
                        r_state <= c_RD;
                    end
                end
                c_RD: begin
                    r_state <= c_MAC;
                end
                c_MAC: begin
                    r_sum <= w_sum_next;
                    if (r_k == c_LAST) begin
                        r_out   <= w_out_map;
                        r_state <= c_EMIT;
                    end else begin
                        r_k     <= r_k + IW'(1);
                        r_state <= c_RD;
                    end
                end
                c_EMIT: begin
                    if (OUT_READY) begin
                        if (r_i == c_LAST && r_j == c_LAST) begin
                            r_state <= c_FIN;
                        end else begin
                            if (r_j == c_LAST) begin
                                r_j <= '0;
                                r_i <= r_i + IW'(1);
                            end else begin
                                r_j <= r_j + IW'(1);
                            end
                            r_k     <= '0;
                            r_sum   <= '0;
                            r_state <= c_RD;
                        end
                    end
                end
                c_FIN: begin
                    r_state <= c_IDLE;
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    assign w_rd   = (r_state == c_RD);
    assign w_emit = (r_state == c_EMIT);

    // Outputs are decoded from state so reset forces every one of them to 0.
    assign READ_EN_A = w_rd;
    assign READ_EN_B = w_rd;
    assign ADDR_A    = w_rd ? (AW'(r_i) * AW'(N) + AW'(r_k)) : '0;
    assign ADDR_B    = w_rd ? (AW'(r_k) * AW'(N) + AW'(r_j)) : '0;
    assign OUT_VALID = w_emit;
    assign OUT       = w_emit ? r_out : '0;
    assign OUT_ROW   = w_emit ? r_i : '0;
    assign OUT_COL   = w_emit ? r_j : '0;
    assign BUSY      = (r_state != c_IDLE);
    assign DONE      = (r_state == c_FIN);

endmodule
`default_nettype wire

// File: tb/tb_matmul_fsmd_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_matmul_fsmd_param
// Brief    : Directed table-driven bench; three N=3 variants run in lockstep
//            (OW8/SAT, OW16/SAT, OW8/truncate) plus an N=1 instance.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_matmul_fsmd_param;

    typedef struct packed {
        logic [8:0][7:0]  a;
        logic [8:0][7:0]  b;
        logic [8:0][15:0] e8s;
        logic [8:0][15:0] e16;
        logic [8:0][15:0] e8t;
        logic [7:0]       stall_idx;
        logic [7:0]       stall_len;
        logic             go_mid;
        logic [7:0]       cycles;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic r_rst_n, r_go, r_rdy, r_go1;
    logic [7:0] mem_a [9];
    logic [7:0] mem_b [9];
    logic [7:0] mem1_a, mem1_b;

    logic       w_rea_0, w_reb_0, w_ov_0, w_busy_0, w_done_0;
    logic [3:0] w_ada_0, w_adb_0;
    logic [7:0] w_out_0, r_da_0, r_db_0;
    logic [1:0] w_row_0, w_col_0;
    logic       w_rea_1, w_reb_1, w_ov_1, w_busy_1, w_done_1;
    logic [3:0] w_ada_1, w_adb_1;
    logic [15:0] w_out_1;
    logic [7:0] r_da_1, r_db_1;
    logic [1:0] w_row_1, w_col_1;
    logic       w_rea_2, w_reb_2, w_ov_2, w_busy_2, w_done_2;
    logic [3:0] w_ada_2, w_adb_2;
    logic [7:0] w_out_2, r_da_2, r_db_2;
    logic [1:0] w_row_2, w_col_2;
    logic       w_rea_3, w_reb_3, w_ov_3, w_busy_3, w_done_3;
    logic       w_ada_3, w_adb_3, w_row_3, w_col_3;
    logic [7:0] w_out_3, r_da_3, r_db_3;

    matmul_fsmd_param #(.N(3), .DW(8), .OW(8), .SAT(1)) u_d8s (
        .CLK(clk), .RST(r_rst_n), .go_i(r_go),
        .READ_EN_A(w_rea_0), .ADDR_A(w_ada_0), .DATA_A(r_da_0),
        .READ_EN_B(w_reb_0), .ADDR_B(w_adb_0), .DATA_B(r_db_0),
        .OUT_VALID(w_ov_0), .OUT_READY(r_rdy), .OUT(w_out_0),
        .OUT_ROW(w_row_0), .OUT_COL(w_col_0), .BUSY(w_busy_0), .DONE(w_done_0));

    matmul_fsmd_param #(.N(3), .DW(8), .OW(16), .SAT(1)) u_d16 (
        .CLK(clk), .RST(r_rst_n), .go_i(r_go),
        .READ_EN_A(w_rea_1), .ADDR_A(w_ada_1), .DATA_A(r_da_1),
        .READ_EN_B(w_reb_1), .ADDR_B(w_adb_1), .DATA_B(r_db_1),
        .OUT_VALID(w_ov_1), .OUT_READY(r_rdy), .OUT(w_out_1),
        .OUT_ROW(w_row_1), .OUT_COL(w_col_1), .BUSY(w_busy_1), .DONE(w_done_1));

    matmul_fsmd_param #(.N(3), .DW(8), .OW(8), .SAT(0)) u_d8t (
        .CLK(clk), .RST(r_rst_n), .go_i(r_go),
        .READ_EN_A(w_rea_2), .ADDR_A(w_ada_2), .DATA_A(r_da_2),
        .READ_EN_B(w_reb_2), .ADDR_B(w_adb_2), .DATA_B(r_db_2),
        .OUT_VALID(w_ov_2), .OUT_READY(r_rdy), .OUT(w_out_2),
        .OUT_ROW(w_row_2), .OUT_COL(w_col_2), .BUSY(w_busy_2), .DONE(w_done_2));

    matmul_fsmd_param #(.N(1), .DW(8), .OW(8), .SAT(1)) u_n1 (
        .CLK(clk), .RST(r_rst_n), .go_i(r_go1),
        .READ_EN_A(w_rea_3), .ADDR_A(w_ada_3), .DATA_A(r_da_3),
        .READ_EN_B(w_reb_3), .ADDR_B(w_adb_3), .DATA_B(r_db_3),
        .OUT_VALID(w_ov_3), .OUT_READY(1'b1), .OUT(w_out_3),
        .OUT_ROW(w_row_3), .OUT_COL(w_col_3), .BUSY(w_busy_3), .DONE(w_done_3));

    // Synchronous-read RAM models: data valid the cycle after the strobe.
    always @(posedge clk) begin
        if (w_rea_0) r_da_0 <= mem_a[w_ada_0];
        if (w_reb_0) r_db_0 <= mem_b[w_adb_0];
        if (w_rea_1) r_da_1 <= mem_a[w_ada_1];
        if (w_reb_1) r_db_1 <= mem_b[w_adb_1];
        if (w_rea_2) r_da_2 <= mem_a[w_ada_2];
        if (w_reb_2) r_db_2 <= mem_b[w_adb_2];
        if (w_rea_3) r_da_3 <= (w_ada_3 == 1'b0) ? mem1_a : 8'hxx;
        if (w_reb_3) r_db_3 <= (w_adb_3 == 1'b0) ? mem1_b : 8'hxx;
    end

    logic [15:0] q_v0[$], q_v1[$], q_v2[$], q_v3[$];
    logic [3:0]  q_rc[$];
    int          n_done;
    int          n_total = 0;
    int          n_bad   = 0;

    always @(negedge clk) begin
        if (w_ov_0 && r_rdy) begin
            q_v0.push_back(16'(w_out_0));
            q_rc.push_back({w_row_0, w_col_0});
        end
        if (w_ov_1 && r_rdy) q_v1.push_back(w_out_1);
        if (w_ov_2 && r_rdy) q_v2.push_back(16'(w_out_2));
        if (w_ov_3)          q_v3.push_back(16'(w_out_3));
        if (w_done_0)        n_done++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d", name, act, act, exp);
        end
    endtask

    function automatic logic [31:0] outs_n3();
        return 32'({w_rea_0, w_reb_0, w_ada_0, w_adb_0, w_ov_0, w_out_0, w_row_0,
                    w_col_0, w_busy_0, w_done_0, w_rea_1, w_ov_1, w_out_1 != 16'd0,
                    w_busy_1, w_done_1, w_rea_2, w_ov_2, w_out_2 != 8'd0, w_busy_2});
    endfunction

    task automatic start_run();
        q_v0.delete(); q_v1.delete(); q_v2.delete(); q_rc.delete();
        n_done = 0;
        @(posedge clk); #1; r_go = 1'b1; r_rdy = 1'b1;
        @(posedge clk); #1; r_go = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input int vi);
        int cyc, stalled;
        bit seen;
        logic [7:0] held_o;
        logic [3:0] held_rc;
        for (int k = 0; k < 9; k++) begin
            mem_a[k] = v.a[k];
            mem_b[k] = v.b[k];
        end
        start_run();
        check($sformatf("v%0d busy_start", vi), 32'(w_busy_0), 1);
        cyc = 0; stalled = 0; seen = 1'b0; held_o = '0; held_rc = '0;
        while (!seen && cyc < 400) begin
            @(posedge clk); cyc++; #1;
            if (v.go_mid) r_go = (cyc == 10);
            if (w_done_0) begin
                seen = 1'b1;
                check($sformatf("v%0d done16", vi), 32'(w_done_1), 1);
                check($sformatf("v%0d done8t", vi), 32'(w_done_2), 1);
            end else if (v.stall_len != 0 && q_v0.size() == int'(v.stall_idx)
                         && (w_ov_0 || stalled > 0)) begin
                if (stalled == 0) begin
                    held_o  = w_out_0;
                    held_rc = {w_row_0, w_col_0};
                end else begin
                    check($sformatf("v%0d stall_valid", vi), 32'(w_ov_0), 1);
                    check($sformatf("v%0d stall_out", vi), 32'(w_out_0), 32'(held_o));
                    check($sformatf("v%0d stall_rc", vi), 32'({w_row_0, w_col_0}), 32'(held_rc));
                    check($sformatf("v%0d stall_rd", vi), 32'(w_rea_0 | w_reb_0), 0);
                end
                r_rdy = (stalled >= int'(v.stall_len));
                stalled++;
            end else begin
                r_rdy = 1'b1;
            end
        end
        r_rdy = 1'b1;
        check($sformatf("v%0d done_seen", vi), 32'(seen), 1);
        check($sformatf("v%0d cycles", vi), 32'(cyc), 32'(v.cycles));
        @(posedge clk); #1;
        check($sformatf("v%0d done_pulse", vi), 32'(w_done_0), 0);
        check($sformatf("v%0d busy_end", vi), 32'({w_busy_0, w_busy_1, w_busy_2}), 0);
        check($sformatf("v%0d n_done", vi), 32'(n_done), 1);
        check($sformatf("v%0d count", vi), 32'(q_v0.size() + q_v1.size() + q_v2.size()), 27);
        for (int k = 0; k < 9; k++) begin
            check($sformatf("v%0d e%0d out8s", vi, k),
                  (k < q_v0.size()) ? 32'(q_v0[k]) : 32'hdead, 32'(v.e8s[k]));
            check($sformatf("v%0d e%0d out16", vi, k),
                  (k < q_v1.size()) ? 32'(q_v1[k]) : 32'hdead, 32'(v.e16[k]));
            check($sformatf("v%0d e%0d out8t", vi, k),
                  (k < q_v2.size()) ? 32'(q_v2[k]) : 32'hdead, 32'(v.e8t[k]));
            check($sformatf("v%0d e%0d rowcol", vi, k),
                  (k < q_rc.size()) ? 32'(q_rc[k]) : 32'hdead, 32'(((k / 3) << 2) | (k % 3)));
        end
    endtask

    vec_t vecs [5];
    int   c_gen [9];

    initial begin
        int  cyc;
        bit  found;
        c_gen = '{30, 36, 42, 66, 81, 96, 102, 126, 150};
        for (int t = 0; t < 5; t++) vecs[t] = '0;
        for (int k = 0; k < 9; k++) begin
            // identity, with a stray go pulse mid-run
            vecs[0].a[k] = 8'(k + 1);
            vecs[0].b[k] = (k % 4 == 0) ? 8'd1 : 8'd0;
            vecs[0].e8s[k] = 16'(k + 1);
            vecs[0].e16[k] = 16'(k + 1);
            vecs[0].e8t[k] = 16'(k + 1);
            // general product A x A
            vecs[1].a[k] = 8'(k + 1);
            vecs[1].b[k] = 8'(k + 1);
            vecs[1].e8s[k] = 16'(c_gen[k]);
            vecs[1].e16[k] = 16'(c_gen[k]);
            vecs[1].e8t[k] = 16'(c_gen[k]);
            // all 255: sum 195075
            vecs[2].a[k] = 8'd255;
            vecs[2].b[k] = 8'd255;
            vecs[2].e8s[k] = 16'd255;
            vecs[2].e16[k] = 16'd65535;
            vecs[2].e8t[k] = 16'd3;
            // all 10: sum 300
            vecs[3].a[k] = 8'd10;
            vecs[3].b[k] = 8'd10;
            vecs[3].e8s[k] = 16'd255;
            vecs[3].e16[k] = 16'd300;
            vecs[3].e8t[k] = 16'd44;
        end
        vecs[0].go_mid = 1'b1;
        vecs[0].cycles = 8'd63;
        vecs[1].cycles = 8'd63;
        vecs[2].cycles = 8'd63;
        vecs[3].cycles = 8'd63;
        vecs[4] = vecs[1];
        vecs[4].stall_idx = 8'd4;
        vecs[4].stall_len = 8'd5;
        vecs[4].cycles    = 8'd68;

        r_rst_n = 1'b0; r_go = 1'b0; r_rdy = 1'b1; r_go1 = 1'b0;
        mem1_a = 8'd7; mem1_b = 8'd9;
        for (int k = 0; k < 9; k++) begin
            mem_a[k] = '0;
            mem_b[k] = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        check("reset_outs", outs_n3(), 0);
        check("reset_n1", 32'({w_rea_3, w_ov_3, w_out_3, w_busy_3, w_done_3}), 0);
        r_rst_n = 1'b1;

        for (int t = 0; t < 5; t++) run_vec(vecs[t], t);

        // reset during MAC of element (1,2)
        for (int k = 0; k < 9; k++) begin
            mem_a[k] = vecs[1].a[k];
            mem_b[k] = vecs[1].b[k];
        end
        start_run();
        cyc = 0; found = 1'b0;
        while (!found && cyc < 400) begin
            @(posedge clk); cyc++; #1;
            if (w_rea_0 && q_v0.size() == 5) found = 1'b1;
        end
        check("rst_mid_found", 32'(found), 1);
        @(posedge clk); #1;
        r_rst_n = 1'b0;
        @(posedge clk); #1;
        check("rst_mid_outs", outs_n3(), 0);
        @(posedge clk); #1;
        r_rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_mid_no_done", 32'(n_done), 0);
        check("rst_mid_no_emit", 32'(q_v0.size()), 5);
        check("rst_mid_idle", 32'(w_busy_0), 0);
        run_vec(vecs[1], 5);

        // N=1 instance
        q_v3.delete();
        @(posedge clk); #1; r_go1 = 1'b1;
        @(posedge clk); #1; r_go1 = 1'b0;
        cyc = 0; found = 1'b0;
        while (!found && cyc < 50) begin
            @(posedge clk); cyc++; #1;
            if (w_ov_3) check("n1_rowcol", 32'({w_row_3, w_col_3}), 0);
            if (w_done_3) found = 1'b1;
        end
        check("n1_done_seen", 32'(found), 1);
        check("n1_cycles", 32'(cyc), 3);
        check("n1_count", 32'(q_v3.size()), 1);
        check("n1_out", (q_v3.size() > 0) ? 32'(q_v3[0]) : 32'hdead, 63);
        @(posedge clk); #1;
        check("n1_idle", 32'({w_busy_3, w_done_3}), 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
